// File: rtl/ntsc_clk_pkg.sv
// Shared definitions for the 8x NTSC clock sequencer: state encoding, default divisors and a
// counter-width helper.
package ntsc_clk_pkg;

    typedef enum logic [1:0] {
        StWaitLock  = 2'd0,
        StStabilise = 2'd1,
        StRun       = 2'd2
    } ntsc_state_e;

    localparam int unsigned DefLockFilter   = 4;
    localparam int unsigned DefStableCycles = 1024;
    localparam int unsigned DefVdpDiv       = 8;
    localparam int unsigned DefSndDiv       = 64;
    localparam int unsigned DefI2sDiv       = 2;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Single-cycle clock-enable generator: counts 0..DIV-1 while enabled, registered pulse on the
// cycle whose count is DIV-1. Synchronous clear returns to phase 0.
module ce_divider
    import ntsc_clk_pkg::*;
#(
    parameter int unsigned DIV = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic ce_o
);

    localparam int unsigned CntW = cnt_width(DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ce_q, ce_d;

    // cnt_q always holds the phase of the current cycle, so ce is computed from the next phase.
    always_comb begin
        cnt_d = cnt_q;
        ce_d  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
            ce_d  = (cnt_d == CntLast);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/ntsc_clock_sequencer.sv
// Start-up sequencer for the 8x colourburst clock: qualifies PLL lock, holds downstream reset
// until stable, then issues VDP/sound/I2S clock enables. Lock loss drops back and is recorded.
module ntsc_clock_sequencer
    import ntsc_clk_pkg::*;
#(
    parameter int unsigned LOCK_FILTER   = DefLockFilter,
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned VDP_DIV       = DefVdpDiv,
    parameter int unsigned SND_DIV       = DefSndDiv,
    parameter int unsigned I2S_DIV       = DefI2sDiv
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       lock_lost_clr,
    output logic       sys_reset_out,
    output logic       vdp_ce,
    output logic       snd_ce,
    output logic       i2s_ce,
    output logic [1:0] state,
    output logic       lock_lost
);

    localparam int unsigned FiltW = cnt_width(LOCK_FILTER - 1);
    localparam int unsigned StabW = cnt_width(STABLE_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(LOCK_FILTER - 1);
    localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);

    logic             sync1_q, lock_s_q;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
    ntsc_state_e      state_q, state_d;
    logic             sys_reset_q, sys_reset_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_loss;
    logic             div_clr, div_en;

    always_comb begin
        state_d    = state_q;
        filt_cnt_d = filt_cnt_q;
        stab_cnt_d = stab_cnt_q;
        lock_loss  = 1'b0;
        case (state_q)
            StWaitLock: begin
                stab_cnt_d = '0;
                if (!lock_s_q) begin
                    filt_cnt_d = '0;
                end else if (filt_cnt_q == FiltLast) begin
                    filt_cnt_d = '0;
                    state_d    = StStabilise;
                end else begin
                    filt_cnt_d = filt_cnt_q + 1'b1;
                end
            end
            StStabilise: begin
                if (!lock_s_q) begin
                    lock_loss = 1'b1;
                end else if (stab_cnt_q == StabLast) begin
                    stab_cnt_d = '0;
                    state_d    = StRun;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    lock_loss = 1'b1;
                end
            end
            default: begin
                state_d    = StWaitLock;
                filt_cnt_d = '0;
                stab_cnt_d = '0;
            end
        endcase
        if (lock_loss) begin
            state_d    = StWaitLock;
            filt_cnt_d = '0;
            stab_cnt_d = '0;
        end
        // A new loss wins over a coincident clear.
        lock_lost_d = lock_loss | (lock_lost_q & ~lock_lost_clr);
        sys_reset_d = (state_d != StRun);
    end

    // Dividers sit at phase 0 outside RUN and only advance once RUN is the current state.
    assign div_clr = (state_d != StRun);
    assign div_en  = (state_q == StRun);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= StWaitLock;
            filt_cnt_q  <= '0;
            stab_cnt_q  <= '0;
            sys_reset_q <= 1'b1;
            lock_lost_q <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            filt_cnt_q  <= filt_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            sys_reset_q <= sys_reset_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    ce_divider #(.DIV(VDP_DIV)) u_vdp_div (
        .clock (clock),
        .reset (reset),
        .clr_i (div_clr),
        .en_i  (div_en),
        .ce_o  (vdp_ce)
    );

    ce_divider #(.DIV(SND_DIV)) u_snd_div (
        .clock (clock),
        .reset (reset),
        .clr_i (div_clr),
        .en_i  (div_en),
        .ce_o  (snd_ce)
    );

    ce_divider #(.DIV(I2S_DIV)) u_i2s_div (
        .clock (clock),
        .reset (reset),
        .clr_i (div_clr),
        .en_i  (div_en),
        .ce_o  (i2s_ce)
    );

    assign sys_reset_out = sys_reset_q;
    assign state         = state_q;
    assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_ntsc_clock_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle outputs, a negedge monitor pops and
// compares them against the DUT.
module tb_ntsc_clock_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_locked;
    logic       lock_lost_clr;
    logic       sys_reset_out;
    logic       vdp_ce;
    logic       snd_ce;
    logic       i2s_ce;
    logic [1:0] state;
    logic       lock_lost;

    ntsc_clock_sequencer #(
        .LOCK_FILTER   (4),
        .STABLE_CYCLES (16),
        .VDP_DIV       (8),
        .SND_DIV       (64),
        .I2S_DIV       (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .lock_lost_clr (lock_lost_clr),
        .sys_reset_out (sys_reset_out),
        .vdp_ce        (vdp_ce),
        .snd_ce        (snd_ce),
        .i2s_ce        (i2s_ce),
        .state         (state),
        .lock_lost     (lock_lost)
    );

    typedef struct {
        logic [1:0] st;
        logic       srst;
        logic       vdp;
        logic       snd;
        logic       i2s;
        logic       lost;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   vdp_pulses  = 0;
    int   snd_pulses  = 0;
    int   i2s_pulses  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input string field, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s.%s at %0t: got %0d, want %0d", tag, field, $time, got, want);
        end
    endtask

    function automatic exp_t e_idle(input logic [1:0] st, input logic lost, input string tag);
        exp_t e;
        e.st = st; e.srst = 1'b1; e.vdp = 1'b0; e.snd = 1'b0; e.i2s = 1'b0;
        e.lost = lost; e.tag = tag;
        return e;
    endfunction

    // RUN cycle k: an enable fires when (k+1) is a multiple of its divisor.
    function automatic exp_t e_run(input int k, input logic lost, input string tag);
        exp_t e;
        e.st = 2'd2; e.srst = 1'b0;
        e.vdp = ((k + 1) % 8 == 0);
        e.snd = ((k + 1) % 64 == 0);
        e.i2s = ((k + 1) % 2 == 0);
        e.lost = lost; e.tag = tag;
        return e;
    endfunction

    // Inputs are sampled at the next posedge; e is the output expected right after that edge.
    task automatic tick(input logic r, input logic p, input logic c, input exp_t e);
        reset         = r;
        pll_locked    = p;
        lock_lost_clr = c;
        @(posedge clock);
        #1;
        sb_q.push_back(e);
    endtask

    // From an empty synchroniser with pll_locked held high: 5 cycles WAIT_LOCK, 16 STABILISE, RUN.
    task automatic lock_seq(input int n_run, input logic lost, input string tag);
        for (int j = 1; j <= 5; j++) tick(1'b0, 1'b1, 1'b0, e_idle(2'd0, lost, {tag, "_wait"}));
        for (int j = 6; j <= 21; j++) tick(1'b0, 1'b1, 1'b0, e_idle(2'd1, lost, {tag, "_stab"}));
        for (int k = 0; k < n_run; k++) tick(1'b0, 1'b1, 1'b0, e_run(k, lost, {tag, "_run"}));
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk(mon_e.tag, "state",         32'(state),         32'(mon_e.st));
            chk(mon_e.tag, "sys_reset_out", 32'(sys_reset_out), 32'(mon_e.srst));
            chk(mon_e.tag, "vdp_ce",        32'(vdp_ce),        32'(mon_e.vdp));
            chk(mon_e.tag, "snd_ce",        32'(snd_ce),        32'(mon_e.snd));
            chk(mon_e.tag, "i2s_ce",        32'(i2s_ce),        32'(mon_e.i2s));
            chk(mon_e.tag, "lock_lost",     32'(lock_lost),     32'(mon_e.lost));
            if (mon_e.tag == "seq1_run") begin
                vdp_pulses += int'(vdp_ce === 1'b1);
                snd_pulses += int'(snd_ce === 1'b1);
                i2s_pulses += int'(i2s_ce === 1'b1);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        pll_locked    = 1'b1;
        lock_lost_clr = 1'b0;

        // Reset with the PLL already locked; synchroniser must still be held clear.
        repeat (3) tick(1'b1, 1'b1, 1'b0, e_idle(2'd0, 1'b0, "reset"));
        lock_seq(256, 1'b0, "seq1");

        // Lock drops for 3 cycles in RUN; 2-cycle synchroniser delay before the drop is seen.
        tick(1'b0, 1'b0, 1'b0, e_run(256, 1'b0, "loss_run"));
        tick(1'b0, 1'b0, 1'b0, e_run(257, 1'b0, "loss_run"));
        tick(1'b0, 1'b0, 1'b0, e_idle(2'd0, 1'b1, "loss_wait"));
        lock_seq(24, 1'b1, "relock");

        // Clear alone in RUN, then clear coincident with a new loss, then clear alone again.
        tick(1'b0, 1'b1, 1'b1, e_run(24, 1'b0, "clr_run"));
        tick(1'b0, 1'b1, 1'b0, e_run(25, 1'b0, "clr_run"));
        tick(1'b0, 1'b0, 1'b0, e_run(26, 1'b0, "loss2_run"));
        tick(1'b0, 1'b0, 1'b0, e_run(27, 1'b0, "loss2_run"));
        tick(1'b0, 1'b0, 1'b1, e_idle(2'd0, 1'b1, "clr_coincident"));
        tick(1'b0, 1'b0, 1'b1, e_idle(2'd0, 1'b0, "clr_alone"));

        // Three-high bursts never satisfy a four-cycle filter.
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 4; b++) begin
                tick(1'b0, (b != 3), 1'b0, e_idle(2'd0, 1'b0, "toggle"));
            end
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0, e_idle(2'd0, 1'b0, "flush"));

        // Lock loss during STABILISE.
        for (int j = 1; j <= 5; j++) tick(1'b0, 1'b1, 1'b0, e_idle(2'd0, 1'b0, "stab_wait"));
        tick(1'b0, 1'b1, 1'b0, e_idle(2'd1, 1'b0, "stab_enter"));
        tick(1'b0, 1'b0, 1'b0, e_idle(2'd1, 1'b0, "stab_drop"));
        tick(1'b0, 1'b0, 1'b0, e_idle(2'd1, 1'b0, "stab_drop"));
        tick(1'b0, 1'b0, 1'b0, e_idle(2'd0, 1'b1, "stab_loss"));

        // Back to RUN, then reset mid-RUN clears everything including the sticky flag.
        lock_seq(10, 1'b1, "seq3");
        tick(1'b1, 1'b1, 1'b0, e_idle(2'd0, 1'b0, "reset_mid_run"));
        tick(1'b0, 1'b1, 1'b0, e_idle(2'd0, 1'b0, "after_reset"));

        repeat (2) @(negedge clock);
        #1;
        chk("end", "scoreboard_left", 32'(sb_q.size()), 32'd0);
        chk("seq1", "vdp_pulses", 32'(vdp_pulses), 32'd32);
        chk("seq1", "snd_pulses", 32'(snd_pulses), 32'd4);
        chk("seq1", "i2s_pulses", 32'(i2s_pulses), 32'd128);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
